mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 42 ++++
 rtl/mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: widths,
// request encodings, access-size codes and FSM state types.
package mem_ctrl_pkg;

  localparam int unsigned Funct3Len = 3;
  localparam int unsigned RegLen    = 32;
  localparam int unsigned AddrLen   = 32;

  localparam logic Read    = 1'b0;
  localparam logic Write   = 1'b1;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [RegLen-1:0] ZERO_WORD = '0;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_MEM,
    OWN_IF
  } owner_t;

  // Number of RAM byte cycles for a given access size; code 11 behaves as word.
  function automatic logic [2:0] access_len(input logic [1:0] size);
    case (size)
      SizeByte: access_len = 3'd1;
      SizeHalf: access_len = 3'd2;
      SizeWord: access_len = 3'd4;
      default:  access_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller arbitrating instruction fetch and load/store traffic
// onto a byte-wide RAM. Each access is split into byte-serial RAM cycles;
// completion is reported with one-cycle pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrLen,
  parameter int unsigned DATA_W = RegLen
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_enable_i,
  input  logic                 wr_i,
  input  logic [Funct3Len-1:0] funct3_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    store_data_i,
  output logic                 load_store_ready_o,
  output logic                 memctrl_off_o,
  output logic [DATA_W-1:0]    load_data_o,
  input  logic                 if_req_i,
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic                 if_flush_i,
  output logic                 inst_ready_o,
  output logic [DATA_W-1:0]    inst_o,
  input  logic [7:0]           ram_din_i,
  output logic [7:0]           ram_dout_o,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic                 ram_wr_o
);

  state_t              state_q, state_d;
  owner_t              owner_q;
  logic [2:0]          cnt_q;
  logic [2:0]          len_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   lanes_q;
  logic                accept_mem;
  logic                accept_if;
  logic                flush_if;
  logic [1:0]          lane_idx;
  logic                unused_f3;

  // Only the low two funct3 bits select the access size.
  assign unused_f3 = funct3_i[2];

  // Request qualification: MEM wins over IF in IDLE; flush only touches fetches.
  always_comb begin
    accept_mem = (state_q == IDLE) && (wr_enable_i == Enable);
    accept_if  = (state_q == IDLE) && !accept_mem && if_req_i && !if_flush_i;
    flush_if   = (owner_q == OWN_IF) && if_flush_i &&
                 ((state_q == READ) || (state_q == DONE));
    // In READ, cnt=k (k>=1) is the cycle in which byte k-1 is on ram_din_i.
    lane_idx   = cnt_q[1:0] - 2'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_mem) begin
          state_d = (wr_i == Write) ? WRITE : READ;
        end else if (accept_if) begin
          state_d = READ;
        end
      end
      READ: begin
        if (flush_if) begin
          state_d = IDLE;
        end else if (cnt_q == len_q) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches, byte counter and read lane capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_MEM;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      lanes_q <= ZERO_WORD;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept_mem) begin
            owner_q <= OWN_MEM;
            len_q   <= access_len(funct3_i[1:0]);
            base_q  <= mem_addr_i;
            wdata_q <= store_data_i;
            lanes_q <= ZERO_WORD;
          end else if (accept_if) begin
            owner_q <= OWN_IF;
            len_q   <= 3'd4;
            base_q  <= pc_i;
            lanes_q <= ZERO_WORD;
          end
        end
        READ: begin
          if (flush_if) begin
            lanes_q <= ZERO_WORD;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd0) begin
              lanes_q[{lane_idx, 3'b000} +: 8] <= ram_din_i;
            end
          end
        end
        WRITE:   cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; idle values are all zero.
  always_comb begin
    ram_addr_o         = '0;
    ram_wr_o           = Disable;
    ram_dout_o         = '0;
    load_store_ready_o = Disable;
    memctrl_off_o      = Disable;
    load_data_o        = '0;
    inst_ready_o       = Disable;
    inst_o             = '0;
    unique case (state_q)
      READ: begin
        // The final READ cycle only captures the last byte; no address is issued.
        if (cnt_q < len_q) begin
          ram_addr_o = base_q + ADDR_W'(cnt_q);
        end
      end
      WRITE: begin
        ram_wr_o   = Enable;
        ram_addr_o = base_q + ADDR_W'(cnt_q);
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      DONE: begin
        if (owner_q == OWN_MEM) begin
          load_store_ready_o = Enable;
          memctrl_off_o      = Enable;
          load_data_o        = lanes_q;
        end else if (!if_flush_i) begin
          // A flush arriving in the completion cycle cancels the fetch pulse.
          inst_ready_o = Enable;
          inst_o       = lanes_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM responder, per-cycle
// output capture, and a transaction-level reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_enable_i, wr_i, if_req_i, if_flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] mem_addr_i, store_data_i, pc_i;
  logic        load_store_ready_o, memctrl_off_o, inst_ready_o, ram_wr_o;
  logic [31:0] load_data_o, inst_o, ram_addr_o;
  logic [7:0]  ram_din_i, ram_dout_o;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_enable_i(wr_enable_i), .wr_i(wr_i), .funct3_i(funct3_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .load_store_ready_o(load_store_ready_o), .memctrl_off_o(memctrl_off_o),
    .load_data_o(load_data_o),
    .if_req_i(if_req_i), .pc_i(pc_i), .if_flush_i(if_flush_i),
    .inst_ready_o(inst_ready_o), .inst_o(inst_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o)
  );

  // Byte-wide RAM: unwritten bytes read as a fixed function of the address.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int k = 0; k < n; k++) w = w | (32'(rd(a + 32'(k))) << (8 * k));
    return w;
  endfunction

  function automatic int exp_len(input logic [2:0] f3);
    logic [1:0] s = f3[1:0];
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
    ram_din_i <= rd(ram_addr_o);
  end

  int checks = 0;
  int passed = 0;
  int cyc;
  bit drop_mem, drop_if;

  logic [31:0] s_addr [64];
  logic [7:0]  s_dout [64];
  logic [31:0] s_ld   [64];
  logic [31:0] s_inst [64];
  bit          s_wr   [64];
  bit          s_lsr  [64];
  bit          s_off  [64];
  bit          s_ir   [64];

  // Sample cycle `cyc` at the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    if (cyc < 64) begin
      s_addr[cyc] = ram_addr_o;  s_dout[cyc] = ram_dout_o;
      s_ld[cyc]   = load_data_o; s_inst[cyc] = inst_o;
      s_wr[cyc]   = ram_wr_o;    s_lsr[cyc]  = load_store_ready_o;
      s_off[cyc]  = memctrl_off_o; s_ir[cyc] = inst_ready_o;
    end
    if (drop_mem && load_store_ready_o) wr_enable_i = 1'b0;
    if (drop_if && inst_ready_o) if_req_i = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_test();
    @(posedge clk);
    #1;
    cyc = 0; drop_mem = 0; drop_if = 0;
    for (int i = 0; i < 64; i++) begin
      s_addr[i] = 'x; s_dout[i] = 'x; s_ld[i] = 'x; s_inst[i] = 'x;
      s_wr[i] = 0; s_lsr[i] = 0; s_off[i] = 0; s_ir[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; wr_enable_i = 0; wr_i = 0; if_req_i = 0; if_flush_i = 0;
    funct3_i = 0; mem_addr_i = 0; store_data_i = 0; pc_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_addr_o, ram_wr_o, ram_dout_o, load_store_ready_o, memctrl_off_o,
         inst_ready_o} !== '0)
      $display("FAIL reset_ctrl: got addr=%h wr=%b dout=%h lsr=%b off=%b ir=%b want all 0",
               ram_addr_o, ram_wr_o, ram_dout_o, load_store_ready_o, memctrl_off_o, inst_ready_o);
    else passed++;
    checks++;
    if ({load_data_o, inst_o} !== 64'd0)
      $display("FAIL reset_data: got ld=%h inst=%h want 0", load_data_o, inst_o);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // One isolated transaction checked cycle by cycle against the model.
  task automatic run_txn(input bit fetch, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input string name);
    int n, rdy;
    bit store;
    logic [31:0] exp_w, got_w, obs_wr, exp_wr, obs_lsr, exp_lsr, obs_off, obs_ir, exp_ir;
    n     = fetch ? 4 : exp_len(f3);
    store = !fetch && wr;
    rdy   = store ? n + 1 : n + 2;
    exp_w = store ? 32'd0 : model_word(addr, n);
    begin_test();
    if (fetch) begin
      if_req_i = 1; pc_i = addr;
    end else begin
      wr_enable_i = 1; wr_i = wr; funct3_i = f3; mem_addr_i = addr; store_data_i = data;
    end
    step();
    if_req_i = 0; wr_enable_i = 0;
    mem_addr_i = $urandom; pc_i = $urandom; store_data_i = $urandom;
    repeat (rdy + 2) step();

    for (int k = 1; k <= n; k++) begin
      checks++;
      if (s_addr[k] !== addr + 32'(k - 1))
        $display("FAIL %s addr c%0d: got %h want %h", name, k, s_addr[k], addr + 32'(k - 1));
      else passed++;
      if (store) begin
        checks++;
        if (s_dout[k] !== data[8*(k-1) +: 8])
          $display("FAIL %s dout c%0d: got %h want %h", name, k, s_dout[k], data[8*(k-1) +: 8]);
        else passed++;
      end
    end

    obs_wr = '0; exp_wr = '0; obs_lsr = '0; exp_lsr = '0; obs_off = '0; obs_ir = '0; exp_ir = '0;
    for (int c = 0; c <= rdy + 1; c++) begin
      obs_wr[c] = s_wr[c]; obs_lsr[c] = s_lsr[c]; obs_off[c] = s_off[c]; obs_ir[c] = s_ir[c];
      exp_wr[c] = store && c >= 1 && c <= n;
    end
    if (fetch) exp_ir[rdy] = 1'b1; else exp_lsr[rdy] = 1'b1;
    checks++;
    if (obs_wr !== exp_wr) $display("FAIL %s wr_cycles: got %b want %b", name, obs_wr, exp_wr);
    else passed++;
    checks++;
    if (obs_lsr !== exp_lsr) $display("FAIL %s ready_cycles: got %b want %b", name, obs_lsr, exp_lsr);
    else passed++;
    checks++;
    if (obs_off !== exp_lsr) $display("FAIL %s off_cycles: got %b want %b", name, obs_off, exp_lsr);
    else passed++;
    checks++;
    if (obs_ir !== exp_ir) $display("FAIL %s inst_ready_cycles: got %b want %b", name, obs_ir, exp_ir);
    else passed++;

    if (store) begin
      got_w = model_word(addr, n);
      exp_w = (n == 4) ? data : (data & ((32'd1 << (8 * n)) - 32'd1));
      checks++;
      if (got_w !== exp_w) $display("FAIL %s ram_after: got %h want %h", name, got_w, exp_w);
      else passed++;
    end else if (fetch) begin
      checks++;
      if (s_inst[rdy] !== exp_w) $display("FAIL %s inst: got %h want %h", name, s_inst[rdy], exp_w);
      else passed++;
    end else begin
      checks++;
      if (s_ld[rdy] !== exp_w) $display("FAIL %s load_data: got %h want %h", name, s_ld[rdy], exp_w);
      else passed++;
    end
  endtask

  task automatic test_directed();
    ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
    run_txn(1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, "lw");
    checks++;
    if (s_ld[6] !== 32'h12345678) $display("FAIL lw_value: got %h want 12345678", s_ld[6]);
    else passed++;
    run_txn(1'b0, 1'b1, 3'b000, 32'h20, 32'hAABBCCDD, "sb");
    run_txn(1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, "lh_wrap");
    checks++;
    if (s_ld[4][31:16] !== 16'h0) $display("FAIL lh_upper: got %h want 0000", s_ld[4][31:16]);
    else passed++;
    run_txn(1'b0, 1'b1, 3'b110, 32'h400, 32'hCAFEF00D, "sw");
    run_txn(1'b1, 1'b0, 3'b000, 32'h400, 32'h0, "fetch");
  endtask

  task automatic test_random();
    bit fetch, wr;
    logic [2:0] f3;
    logic [31:0] addr;
    for (int i = 0; i < 24; i++) begin
      fetch = ($urandom_range(0, 3) == 0);
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      run_txn(fetch, wr, f3, addr, $urandom, "rand");
    end
  endtask

  task automatic test_contention();
    logic [31:0] p, a, d, exp_f, got, obs_lsr, obs_ir, obs_wr, exp_wr;
    p = 32'h0000_8000 + ($urandom & 32'hFFC); a = 32'h0002_0000 + ($urandom & 32'hFFF); d = $urandom;
    exp_f = model_word(p, 4);
    begin_test();
    if_req_i = 1; pc_i = p;
    step();
    if_req_i = 0;
    step();
    wr_enable_i = 1; wr_i = 1; funct3_i = 3'b010; mem_addr_i = a; store_data_i = d;
    drop_mem = 1;
    repeat (12) step();
    obs_lsr = '0; obs_ir = '0; obs_wr = '0; exp_wr = '0;
    for (int c = 0; c < 14; c++) begin
      obs_lsr[c] = s_lsr[c]; obs_ir[c] = s_ir[c]; obs_wr[c] = s_wr[c];
      exp_wr[c] = (c >= 8 && c <= 11);
    end
    checks++;
    if (obs_ir !== 32'h1 << 6) $display("FAIL contend_fetch_ready: got %b want bit 6", obs_ir);
    else passed++;
    checks++;
    if (obs_lsr !== 32'h1 << 12) $display("FAIL contend_sw_ready: got %b want bit 12", obs_lsr);
    else passed++;
    checks++;
    if (obs_wr !== exp_wr) $display("FAIL contend_sw_writes: got %b want %b", obs_wr, exp_wr);
    else passed++;
    checks++;
    if (s_inst[6] !== exp_f) $display("FAIL contend_inst: got %h want %h", s_inst[6], exp_f);
    else passed++;
    checks++;
    if (s_addr[8] !== a) $display("FAIL contend_sw_addr: got %h want %h", s_addr[8], a);
    else passed++;
    got = model_word(a, 4);
    checks++;
    if (got !== d) $display("FAIL contend_ram: got %h want %h", got, d);
    else passed++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] p, a, exp_l, exp_f, obs_lsr, obs_ir;
    p = $urandom; a = $urandom;
    exp_l = model_word(a, 4); exp_f = model_word(p, 4);
    begin_test();
    if_req_i = 1; pc_i = p;
    wr_enable_i = 1; wr_i = 0; funct3_i = 3'b010; mem_addr_i = a;
    drop_mem = 1; drop_if = 1;
    repeat (15) step();
    obs_lsr = '0; obs_ir = '0;
    for (int c = 0; c < 15; c++) begin
      obs_lsr[c] = s_lsr[c]; obs_ir[c] = s_ir[c];
    end
    checks++;
    if (obs_lsr !== 32'h1 << 6) $display("FAIL tie_mem_ready: got %b want bit 6", obs_lsr);
    else passed++;
    checks++;
    if (obs_ir !== 32'h1 << 13) $display("FAIL tie_fetch_ready: got %b want bit 13", obs_ir);
    else passed++;
    checks++;
    if (s_ld[6] !== exp_l) $display("FAIL tie_load: got %h want %h", s_ld[6], exp_l);
    else passed++;
    checks++;
    if (s_inst[13] !== exp_f) $display("FAIL tie_inst: got %h want %h", s_inst[13], exp_f);
    else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] p1, p2, exp_f, obs_ir;
    p1 = $urandom; p2 = $urandom;
    exp_f = model_word(p2, 4);
    begin_test();
    if_req_i = 1; pc_i = p1;
    step();
    if_req_i = 0;
    repeat (2) step();
    if_flush_i = 1;
    step();
    if_flush_i = 0;
    if_req_i = 1; pc_i = p2;
    step();
    if_req_i = 0;
    repeat (8) step();
    obs_ir = '0;
    for (int c = 0; c < 13; c++) obs_ir[c] = s_ir[c];
    checks++;
    if (obs_ir !== 32'h1 << 10) $display("FAIL flush_ready: got %b want bit 10", obs_ir);
    else passed++;
    checks++;
    if (s_addr[5] !== p2) $display("FAIL flush_refetch_addr: got %h want %h", s_addr[5], p2);
    else passed++;
    checks++;
    if (s_inst[10] !== exp_f) $display("FAIL flush_refetch_inst: got %h want %h", s_inst[10], exp_f);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs_lsr, obs_wr;
    begin_test();
    wr_enable_i = 1; wr_i = 1; funct3_i = 3'b010; mem_addr_i = 32'h300; store_data_i = $urandom;
    step();
    wr_enable_i = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (6) step();
    checks++;
    if ({s_addr[3], s_wr[3], s_dout[3], s_lsr[3], s_off[3], s_ir[3], s_ld[3], s_inst[3]} !== '0)
      $display("FAIL rst_mid_outputs: got addr=%h wr=%b dout=%h lsr=%b off=%b ir=%b ld=%h inst=%h want 0",
               s_addr[3], s_wr[3], s_dout[3], s_lsr[3], s_off[3], s_ir[3], s_ld[3], s_inst[3]);
    else passed++;
    obs_lsr = '0; obs_wr = '0;
    for (int c = 0; c < 9; c++) begin
      obs_lsr[c] = s_lsr[c] | s_off[c];
      if (c >= 3) obs_wr[c] = s_wr[c];
    end
    checks++;
    if (obs_lsr !== 32'd0) $display("FAIL rst_mid_no_ready: got %b want 0", obs_lsr);
    else passed++;
    checks++;
    if (obs_wr !== 32'd0) $display("FAIL rst_mid_no_write: got %b want 0", obs_wr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_contention();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
